// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST controller.
// Holds the FSM state enum, LFSR/opcode widths, the default seed and golden
// signature, and the LFSR next-state helper used by the pattern generator.
package bist_pkg;

  localparam int          LFSR_WIDTH     = 16;
  localparam int          OP_WIDTH       = 3;
  localparam int          SIG_WIDTH      = 8;
  localparam logic [15:0] DEFAULT_SEED   = 16'hACE1;
  localparam logic [7:0]  DEFAULT_GOLDEN = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_COMPARE,
    ST_DONE
  } bist_state_t;

  // Fibonacci step for x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[LFSR_WIDTH-1:1]};
  endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit Fibonacci LFSR pattern source.
// Ports:
//   clk, reset : clock and synchronous active-high reset (q <= RESET_VAL)
//   load, seed : load seed value (has priority over en)
//   en         : advance one step
//   q          : current LFSR contents
module bist_lfsr16
  import bist_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] RESET_VAL = DEFAULT_SEED
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [LFSR_WIDTH-1:0] seed,
  input  logic                  en,
  output logic [LFSR_WIDTH-1:0] q
);

  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load)    lfsr_d = seed;
    else if (en) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= RESET_VAL;
    else       lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/bist_controller.sv
// BIST controller: on start, holds the signature analyzer in reset for one
// INIT cycle, drives NUM_PATTERNS LFSR-derived operand/opcode vectors, then
// latches the analyzer signature and compares it with GOLDEN_SIG.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : run request, honoured only in IDLE/DONE
//   signature           : analyzer output
//   test_a/test_b/test_op : CUT stimulus (follows the LFSR combinationally)
//   sa_reset            : registered analyzer reset, low only during RUN
//   busy, done, pass    : status; pass valid while done
//   sig_captured        : signature latched at the end of COMPARE
module bist_controller
  import bist_pkg::*;
#(
  parameter int                    NUM_PATTERNS = 255,
  parameter logic [LFSR_WIDTH-1:0] SEED         = DEFAULT_SEED,
  parameter logic [SIG_WIDTH-1:0]  GOLDEN_SIG   = DEFAULT_GOLDEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SIG_WIDTH-1:0] signature,
  output logic [7:0]           test_a,
  output logic [7:0]           test_b,
  output logic [OP_WIDTH-1:0]  test_op,
  output logic                 sa_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_WIDTH-1:0] sig_captured
);

  localparam logic [15:0] LAST_CNT = 16'(NUM_PATTERNS - 1);

  bist_state_t            state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   sa_reset_q, sa_reset_d;
  logic                   pass_q, pass_d;
  logic [SIG_WIDTH-1:0]   sig_q, sig_d;
  logic [LFSR_WIDTH-1:0]  lfsr;

  bist_lfsr16 #(.RESET_VAL(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (state_q == ST_INIT),
    .seed  (SEED),
    .en    (state_q == ST_RUN),
    .q     (lfsr)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    sig_d   = sig_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_INIT;
      ST_INIT: begin
        state_d = ST_RUN;
        cnt_d   = '0;
        pass_d  = 1'b0;
        sig_d   = '0;
      end
      ST_RUN: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == LAST_CNT) state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        state_d = ST_DONE;
        sig_d   = signature;
        pass_d  = (signature == GOLDEN_SIG);
      end
      default: state_d = ST_IDLE;
    endcase
    // Decoded from next state so the analyzer sees a clean registered level
    // that is low for exactly the RUN cycles.
    sa_reset_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sa_reset_q <= 1'b1;
      pass_q     <= 1'b0;
      sig_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sa_reset_q <= sa_reset_d;
      pass_q     <= pass_d;
      sig_q      <= sig_d;
    end
  end

  assign test_a       = lfsr[7:0];
  assign test_b       = lfsr[15:8];
  assign test_op      = lfsr[2:0] ^ lfsr[10:8];
  assign sa_reset     = sa_reset_q;
  assign busy         = (state_q == ST_INIT) || (state_q == ST_RUN) || (state_q == ST_COMPARE);
  assign done         = (state_q == ST_DONE);
  assign pass         = pass_q;
  assign sig_captured = sig_q;

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller with a behavioral ALU + MISR standing in
// for the CUT and signature analyzer. Patterns for N=4 from seed ACE1:
//   ACE1 op5, 5670 op6, AB38 op3, 559C op1; LFSR ends at 2ACE.
// ALU outs: 1E, E0, BB, 47 -> MISR signature 43 (stuck bit0: BA,46 -> 40).
// N=1 instance: single pattern ~E1 = 1E -> signature 1E.
module tb_bist_controller;

  logic clk, reset, start, stuck;
  logic [7:0] sig0, sig1;
  logic [7:0] a0, b0, a1, b1, sc0, sc1;
  logic [2:0] op0, op1;
  logic sar0, sar1, busy0, busy1, done0, done1, pass0, pass1;
  int n_cmp, n_err, cyc;

  bist_controller #(.NUM_PATTERNS(4), .SEED(16'hACE1), .GOLDEN_SIG(8'h43)) dut (
    .clk(clk), .reset(reset), .start(start), .signature(sig0),
    .test_a(a0), .test_b(b0), .test_op(op0), .sa_reset(sar0),
    .busy(busy0), .done(done0), .pass(pass0), .sig_captured(sc0));

  bist_controller #(.NUM_PATTERNS(1), .SEED(16'hACE1), .GOLDEN_SIG(8'h1E)) dut1 (
    .clk(clk), .reset(reset), .start(start), .signature(sig1),
    .test_a(a1), .test_b(b1), .test_op(op1), .sa_reset(sar1),
    .busy(busy1), .done(done1), .pass(pass1), .sig_captured(sc1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  function automatic logic [7:0] misr(input logic [7:0] s, input logic [7:0] o);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ o ^ {7'b0, (o == 8'h00)};
  endfunction

  logic [7:0] out0, out1;
  assign out0 = alu(a0, b0, op0) & (stuck ? 8'hFE : 8'hFF);
  assign out1 = alu(a1, b1, op1);

  always @(posedge clk) begin
    if (sar0) sig0 <= 8'h00; else sig0 <= misr(sig0, out0);
    if (sar1) sig1 <= 8'h00; else sig1 <= misr(sig1, out1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Steps until done (bounded); c counts edges since the start edge.
  task automatic wait_done(input int from, input bit pulse, output int c);
    c = from;
    while (!done0 && c < 40) begin
      if (pulse && c == 3) start = 1'b1;
      step();
      start = 1'b0;
      c++;
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; stuck = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_sa_reset", 16'(sar0), 16'h1);
    check("rst_busy",     16'(busy0), 16'h0);
    check("rst_done",     16'(done0), 16'h0);
    check("rst_pass",     16'(pass0), 16'h0);
    check("rst_sig",      16'(sc0), 16'h00);
    check("rst_pattern",  {b0, a0}, 16'hACE1);
    check("rst_op",       16'(op0), 16'h5);

    // Run A: detailed walk through N=4
    start = 1'b1; step(); start = 1'b0;          // edge 0 -> INIT
    check("init_busy", 16'(busy0), 16'h1);
    check("init_sa",   16'(sar0), 16'h1);
    step();                                      // RUN0
    check("run0_pat", {b0, a0}, 16'hACE1);
    check("run0_op",  16'(op0), 16'h5);
    check("run0_sa",  16'(sar0), 16'h0);
    step();                                      // RUN1
    check("run1_pat", {b0, a0}, 16'h5670);
    check("run1_op",  16'(op0), 16'h6);
    check("n1_done_early", 16'(done1), 16'h0);
    step();                                      // RUN2
    check("run2_pat", {b0, a0}, 16'hAB38);
    check("run2_op",  16'(op0), 16'h3);
    check("n1_done",  16'(done1), 16'h1);
    check("n1_pass",  16'(pass1), 16'h1);
    check("n1_sig",   16'(sc1), 16'h1E);
    step();                                      // RUN3
    check("run3_pat", {b0, a0}, 16'h559C);
    check("run3_op",  16'(op0), 16'h1);
    step();                                      // COMPARE
    check("cmp_busy", 16'(busy0), 16'h1);
    check("cmp_done", 16'(done0), 16'h0);
    check("cmp_sa",   16'(sar0), 16'h1);
    wait_done(5, 1'b0, cyc);
    check("latency_a", 16'(cyc), 16'd6);
    check("a_pass",    16'(pass0), 16'h1);
    check("a_sig",     16'(sc0), 16'h43);
    check("a_final_pat", {b0, a0}, 16'h2ACE);
    check("done_busy", 16'(busy0), 16'h0);

    // Run B: back-to-back restart from DONE, start pulsed mid-RUN
    start = 1'b1; step(); start = 1'b0;          // INIT
    check("b_init_done", 16'(done0), 16'h0);
    check("b_init_sa",   16'(sar0), 16'h1);
    step();                                      // RUN0
    check("b_pass_clr",  16'(pass0), 16'h0);
    check("b_sig_clr",   16'(sc0), 16'h00);
    check("b_run0_pat",  {b0, a0}, 16'hACE1);
    wait_done(1, 1'b1, cyc);
    check("latency_b", 16'(cyc), 16'd6);
    check("b_pass",    16'(pass0), 16'h1);
    check("b_sig",     16'(sc0), 16'h43);

    // Run C: CUT output bit 0 stuck at 0
    stuck = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    wait_done(0, 1'b0, cyc);
    check("latency_c", 16'(cyc), 16'd6);
    check("c_pass",    16'(pass0), 16'h0);
    check("c_sig",     16'(sc0), 16'h40);
    stuck = 1'b0;

    // Run D: reset in RUN cycle 2, then a fresh run
    start = 1'b1; step(); start = 1'b0;          // INIT
    step(); step(); step();                      // RUN2
    check("d_run2_pat", {b0, a0}, 16'hAB38);
    reset = 1'b1; step(); reset = 1'b0;
    check("d_rst_busy", 16'(busy0), 16'h0);
    check("d_rst_sa",   16'(sar0), 16'h1);
    check("d_rst_done", 16'(done0), 16'h0);
    check("d_rst_sig",  16'(sc0), 16'h00);
    check("d_rst_pat",  {b0, a0}, 16'hACE1);
    step();
    check("d_idle_busy", 16'(busy0), 16'h0);
    start = 1'b1; step(); start = 1'b0;
    step();
    check("d_run0_pat", {b0, a0}, 16'hACE1);
    wait_done(1, 1'b0, cyc);
    check("latency_d", 16'(cyc), 16'd6);
    check("d_pass",    16'(pass0), 16'h1);
    check("d_sig",     16'(sc0), 16'h43);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bist_controller.md
# bist_controller

Built-in self-test controller and test-pattern generator feeding the circuit under test (CUT) whose `OUT`/`ZERO` response is compressed by the signature analyzer. On `start` it clears the analyzer, drives `NUM_PATTERNS` pseudo-random operand/opcode vectors from a 16-bit LFSR, then captures the final signature and flags pass or fail against a golden value. It is the stage directly upstream of the analyzer, and it owns that analyzer's reset.

## Interface
Parameters:
- `NUM_PATTERNS`, default 255: vectors applied per run; legal range 1..65535.
- `SEED`, default 16'hACE1: LFSR load value; must be nonzero.
- `GOLDEN_SIG`, default 8'h00: expected analyzer signature after a clean run.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: single-cycle request; sampled only in IDLE or DONE.
- `signature`  in  8: signature analyzer output.
- `test_a`  out  8: CUT operand A.
- `test_b`  out  8: CUT operand B.
- `test_op`  out  3: CUT opcode.
- `sa_reset`  out  1: registered reset to the analyzer (glitch-free).
- `busy`  out  1: high in INIT, RUN and COMPARE.
- `done`  out  1: high in DONE.
- `pass`  out  1: valid while `done` is high.
- `sig_captured`  out  8: latched signature from the last run.

## Operation
- FSM states: IDLE → INIT → RUN → COMPARE → DONE.
  - IDLE/DONE: `start`=1 → INIT.
  - INIT: always → RUN after 1 cycle.
  - RUN: pattern count == `NUM_PATTERNS`−1 → COMPARE, otherwise stay in RUN.
  - COMPARE: always → DONE after 1 cycle.
  - DONE: holds until `start`=1.
- `start` is ignored in INIT, RUN and COMPARE; there is no abort except `reset`.
- LFSR: Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Update: fb = l[0]^l[2]^l[3]^l[5]; next = {fb, l[15:1]}.
  - Loaded with `SEED` in INIT; advances once per RUN cycle.
- Pattern mapping:
  - `test_a` = l[7:0]
  - `test_b` = l[15:8]
  - `test_op` = l[2:0] ^ l[10:8]
- Pattern counter: 16-bit, cleared in INIT, increments each RUN cycle.
- `sa_reset` is registered. It is 0 in every RUN cycle and 1 in all other states.
- COMPARE: at the closing edge, `sig_captured` <= `signature` and `pass` <= (`signature` == `GOLDEN_SIG`).
- `pass` and `sig_captured` hold until the next INIT, where both are cleared.

## Timing
- Reset values:
  - state IDLE, LFSR = `SEED`, counter 0.
  - `sa_reset`=1, `busy`=0, `done`=0, `pass`=0, `sig_captured`=8'h00.
  - `test_a`=8'hE1, `test_b`=8'hAC, `test_op`=3'b101, since outputs follow the LFSR.
- Run timeline, with `start` seen at edge t0:
  - INIT occupies t0..t1.
  - RUN cycle k (k = 0..N−1) presents pattern k, and the analyzer captures its CUT response at the end of that cycle.
  - COMPARE sees the signature after exactly N captures.
  - `done` rises N+2 cycles after the `start` edge.
- `start` asserted in DONE restarts immediately. `done` drops at the following edge and the prior `pass` is cleared in INIT.
- The analyzer keeps clocking after COMPARE, so only `sig_captured` is authoritative.
- `reset` mid-RUN: at the next edge all state takes its reset values and `sa_reset` returns to 1; no partial result is reported.
- With `NUM_PATTERNS`=1, RUN lasts one cycle.

## Structure
- `bist_pkg`:
  - state enum `bist_state_t`
  - `LFSR_WIDTH`=16
  - default seed and golden constants
  - opcode width (3)
- Sub-module `bist_lfsr16`, with ports `clk`, `reset`, `load`, `seed`, `en`, `q[15:0]`, instantiated once.
- FSM, counter and comparator live in `bist_controller`.

## Test plan
- Reset, then idle → `sa_reset`=1, `done`=0, `test_a`/`test_b`/`test_op` = E1/AC/101.
- `start` with N=4 and a behavioral ALU plus analyzer model → RUN cycle 0 shows A=E1/B=AC, cycle 1 shows A=70/B=56; `done` rises 6 cycles after `start`.
- `GOLDEN_SIG` set to the model signature → `pass`=1 and `sig_captured` = model value. With one CUT output bit forced stuck-at-0 → `pass`=0.
- `start` pulsed during RUN → ignored; pattern count and `done` timing unchanged.
- `reset` asserted in RUN cycle 2 → next cycle IDLE, `sa_reset`=1, `busy`=0. A new `start` reproduces the E1/AC first pattern.
- Back-to-back: `start` in DONE → `pass` cleared in INIT, the second run yields an identical signature, and `sa_reset` pulses high for ≥1 cycle between runs.
